// File: rtl/t_ff_pkg.sv
// ---------------------------------------------------------------------------
// t_ff_pkg
// Shared definitions for the T flip-flop counter slice:
//   - TFF_W       : width of one T cell's T/Q/Qbar ports
//   - mod_is_legal: elaboration-time legality test for a modulus vs. width
// ---------------------------------------------------------------------------
package t_ff_pkg;

  // Each T cell holds exactly one bit of state.
  localparam int TFF_W = 1;

  // A modulus is usable when it spans at least two states and fits in the
  // count width (2**width itself is allowed and wraps naturally).
  function automatic bit mod_is_legal(input int width, input int modulus);
    return (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// ---------------------------------------------------------------------------
// t_ff_cell
// Single toggle flip-flop: Q flips on a rising clk edge whenever T is 1.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active-high, clears Q to 0
//   T     in   toggle request
//   Q     out  stored bit
//   Qbar  out  complement of Q
// ---------------------------------------------------------------------------
module t_ff_cell
  import t_ff_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [TFF_W-1:0] T,
  output logic [TFF_W-1:0] Q,
  output logic [TFF_W-1:0] Qbar
);

  logic [TFF_W-1:0] q_d;
  logic [TFF_W-1:0] q_q;

  always_comb begin
    q_d = q_q ^ T;
  end

  // NOTE: state flops use non-blocking (<=) so every register samples the
  // values from before the edge, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q    = q_q;
  assign Qbar = ~q_q;

endmodule

// File: rtl/t_mod_counter.sv
// ---------------------------------------------------------------------------
// t_mod_counter
// Synchronous modulo-MOD up/down counter built from WIDTH T flip-flop cells.
// The next count is chosen by a priority mux (load > count > hold) and each
// cell's T input is the XOR of its current and next bit.
// The count width equals the number of T cells; the modulus sets the count
// range 0..MOD-1 and must lie between 2 and 2**WIDTH inclusive.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   en        in   count enable
//   up        in   1 = count up, 0 = count down
//   load      in   parallel load strobe, overrides en
//   din       in   load value
//   q         out  current count
//   qbar      out  bitwise complement of q
//   tc        out  terminal count (combinational)
//   wrap      out  one-cycle pulse after a wrap-around edge
//   load_err  out  one-cycle pulse after a load with din >= MOD
// ---------------------------------------------------------------------------
module t_mod_counter
  import t_ff_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (!mod_is_legal(WIDTH, MOD)) begin : g_mod_check
    $error("t_mod_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  // Top count value and the modulus widened by one bit so MOD = 2**WIDTH
  // still compares correctly against din.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] t_vec;
  logic             wrap_d;
  logic             wrap_q;
  logic             load_err_d;
  logic             load_err_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    cnt_nxt    = q;
    load_err_d = 1'b0;
    tc         = 1'b0;

    if (load) begin
      if ({1'b0, din} < MOD_W) begin
        cnt_nxt = din;
      end else begin
        cnt_nxt    = '0;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        tc      = (q == MAX_CNT);
        cnt_nxt = tc ? '0 : q + WIDTH'(1);
      end else begin
        tc      = (q == '0);
        cnt_nxt = tc ? MAX_CNT : q - WIDTH'(1);
      end
    end

    // A terminal-count cycle with en and no load is exactly a wrap edge.
    wrap_d = tc;
  end

  // Each cell toggles only where the next count differs from the current one.
  assign t_vec = q ^ cnt_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .T    (t_vec[i]),
      .Q    (q[i]),
      .Qbar (qbar[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
